cp0_exception_unit: RTL
=======================

# cp0_exception_unit

Coprocessor-0 exception responder for the pipelined MIPS core. It receives exception codes raised in the pipeline, such as the ALU's load/store address-error flags and overflow, plus external hardware interrupts. It decides whether the pipeline must trap, and records SR, Cause and EPC state for the handler. It sits beside the memory stage, serves `mfc0`/`mtc0`, and returns EPC for `eret`.

## Interface
Parameters:
- `PRID_VALUE`, 32'h0000_4D50: read-only value of register 15 (PRId).
- `HW_INT_W`, 6: number of hardware interrupt lines. Must be 6; maps to bits [15:10].

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `A1`  in  5  CP0 read register number (`mfc0`).
- `A2`  in  5  CP0 write register number (`mtc0`).
- `DIn`  in  32  write data.
- `WE`  in  1  write enable for `A2`.
- `VPC`  in  32  PC of the instruction in the memory stage (victim PC).
- `BDIn`  in  1  victim is in a branch delay slot.
- `ExcCodeIn`  in  5  pipeline exception code; 0 means none. Accepted codes: 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- `HWInt`  in  6  level-sensitive hardware interrupt lines.
- `EXLClr`  in  1  `eret` in the memory stage.
- `DOut`  out  32  contents of register `A1`.
- `EPCOut`  out  32  current EPC register.
- `Req`  out  1  trap request: flush the pipeline and redirect fetch to 0x0000_4180.

## Operation
- Register map:
  - 12 SR: IM[15:10], EXL[1] and IE[0] are writable; other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Cause is not writable by `mtc0` (writes ignored).
  - 14 EPC: 32 bits, fully writable.
  - 15 PRId: read-only.
  - Any other `A1` reads 0. Writes to any other `A2` are ignored.
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCodeIn != 0) & !SR.EXL.
- Req = IntReq | ExcReq. Req is combinational from the current inputs and registered state.
- Interrupt has priority over exception. When both are present, the recorded ExcCode is 0.
- On an edge with Req=1:
  - SR.EXL <- 1.
  - Cause.ExcCode <- IntReq ? 0 : ExcCodeIn.
  - Cause.BD <- BDIn.
  - EPC <- BDIn ? VPC - 32'd4 : VPC. EPC keeps the raw VPC (it may be misaligned for fetch AdEL); subtraction wraps mod 2^32.
  - Any `mtc0` write in the same cycle is discarded. The victim never completes.
- On an edge with Req=0:
  - If WE=1, write `DIn` to `A2` per the masks above.
  - If EXLClr=1, set SR.EXL <- 0.
  - If WE targets SR and EXLClr=1 in the same cycle, EXLClr wins for bit 1; the other SR bits take `DIn`.
- Cause.IP <- HWInt on every edge (not reset-gated beyond reset itself), regardless of Req or EXL.
- No internal hold state exists beyond the registers. EXL=1 suppresses nested traps of both kinds.

## Timing
- `resetn`=0 at an edge:
  - SR = 0 (IM=0, EXL=0, IE=0).
  - Cause = 0.
  - EPC = 0.
  - Reset overrides Req, WE and EXLClr in that cycle.
- Outputs while reset is held: Req=0, since IE=0 and EXL=0 imply no interrupt. Exceptions still assert Req combinationally, but the edge does not record them.
- `DOut` and `EPCOut` are combinational from the registers, with zero-cycle read latency. A read in the same cycle as a write to the same register returns the pre-edge value; there is no bypass. The pipeline stalls `eret` behind `mtc0 EPC`.
- Req is valid in the same cycle the inputs present the fault. State is captured on that cycle's edge. From the next cycle, EXL=1 and Req=0 until EXLClr.
- Mid-handler `HWInt` changes are visible in Cause.IP one edge later. They do not raise Req while EXL=1.

## Test plan
- Reset then read: `resetn`=0 for 2 cycles, then A1=12/13/14/15 -> DOut = 0, 0, 0, 32'h0000_4D50; Req=0.
- Overflow trap: ExcCodeIn=12, VPC=0x3010, BDIn=0 -> Req=1 same cycle. Next cycle: EPC=0x3010, Cause=0x0000_0030, SR.EXL=1, Req=0 with ExcCodeIn still 12.
- Delay-slot AdES: ExcCodeIn=5, VPC=0x3024, BDIn=1, WE=1 A2=14 DIn=0xDEAD -> EPC=0x3020, Cause=0x8000_0014; the `mtc0` is discarded.
- Interrupt priority: write SR=0x0000_0401, then HWInt=6'b000001 with ExcCodeIn=4, VPC=0x3100 -> Req=1; Cause.ExcCode=0, IP[10]=1; EPC=0x3100.
- Masked interrupt and eret: SR.IM=0, HWInt=6'b111111 -> Req=0 and Cause.IP=0x3F. Then trap, then EXLClr=1 with WE SR DIn=0x0000_0403 -> SR reads 0x0000_0401.
- Reset mid-handler: EXL=1, EPC=0x3010, assert `resetn`=0 with ExcCodeIn=10 -> SR, Cause and EPC all 0 after the edge.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception responder: decides trap requests and keeps SR, Cause
// and EPC for the handler, serving mfc0/mtc0 and EPC for eret.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4D50,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         DIn,
  input  logic                WE,
  input  logic [31:0]         VPC,
  input  logic                BDIn,
  input  logic [4:0]          ExcCodeIn,
  input  logic [HW_INT_W-1:0] HWInt,
  input  logic                EXLClr,
  output logic [31:0]         DOut,
  output logic [31:0]         EPCOut,
  output logic                Req
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused_din;

  // Trap decision; an open EXL suppresses both interrupts and exceptions.
  assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_sr_exl;
  assign w_req     = w_int_req | w_exc_req;
  assign Req       = w_req;

  assign w_sr         = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
  assign w_cause      = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};
  assign EPCOut       = r_epc;
  assign w_unused_din = ^{DIn[31:16], DIn[9:2]};

  // Register state: a trap capture takes precedence over any mtc0 or eret.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= HWInt;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_req ? 5'd0 : ExcCodeIn;
        r_cause_bd  <= BDIn;
        r_epc       <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (WE && (A2 == REG_SR)) begin
          r_sr_im  <= DIn[15:10];
          r_sr_ie  <= DIn[0];
          r_sr_exl <= EXLClr ? 1'b0 : DIn[1];
        end else if (EXLClr) begin
          r_sr_exl <= 1'b0;
        end else begin
          r_sr_exl <= r_sr_exl;
        end
        if (WE && (A2 == REG_EPC)) begin
          r_epc <= DIn;
        end else begin
          r_epc <= r_epc;
        end
      end
    end
  end

  // mfc0 read port, no bypass of same-cycle writes.
  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
      REG_PRID:  DOut = PRID_VALUE;
      default:   DOut = 32'd0;
    endcase
  end

endmodule
